// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial adder wrapper.
package serial_arith_pkg;

  localparam int SA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Bits needed to count 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand and result handshakes of the serial adder wrapper.
interface serial_add_seq_if #(
  parameter int W = serial_arith_pkg::SA_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/serial_fa.sv
// Combinational 1-bit full adder used as the serial adder cell.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  logic p;

  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);
endmodule

// File: rtl/serial_add_seq.sv
// Parallel-in/parallel-out wrapper around a bit-serial adder, LSB first,
// with optional end-around carry for (a+b) mod 2^W-1.
module serial_add_seq
  import serial_arith_pkg::*;
#(
  parameter int W        = SA_W,
  parameter bit MERSENNE = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_seq_if.slave  bus
);
  localparam int CW = clog2(W);

  sa_state_t    state, state_nxt;
  logic [W-1:0] a_sr, b_sr, sum_sr;
  logic [W-1:0] sum_done;
  logic [CW-1:0] cnt;
  logic         carry, wrap, c_out_q;
  logic         fa_s, fa_co;
  logic         last, accept, do_wrap;
  logic         in_ready, out_valid;

  serial_fa u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c_in (carry),
    .s    (fa_s),
    .c_out(fa_co)
  );

  assign last     = (cnt == CW'(W - 1));
  assign accept   = bus.in_valid && in_ready;
  assign sum_done = {fa_s, sum_sr[W-1:1]};
  // A first-pass carry is folded back in by re-running the sum through the adder with carry=1.
  assign do_wrap  = MERSENNE && !wrap && fa_co && last;

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ADD;
      end
      ADD: begin
        if (last && !do_wrap) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      wrap    <= 1'b0;
      c_out_q <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_sr  <= bus.a;
        b_sr  <= bus.b;
        carry <= 1'b0;
        cnt   <= '0;
        wrap  <= 1'b0;
      end
    end else if (state == ADD) begin
      sum_sr <= sum_done;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_co;
      cnt    <= cnt + 1'b1;
      if (last && !wrap) c_out_q <= fa_co;
      if (do_wrap) begin
        a_sr  <= sum_done;
        b_sr  <= '0;
        carry <= 1'b1;
        cnt   <= '0;
        wrap  <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_sr;
  assign bus.c_out     = c_out_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: one plain instance and one Mersenne instance.
module tb_serial_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_add_seq_if #(.W(8)) bus0 ();
  serial_add_seq_if #(.W(8)) bus1 ();

  serial_add_seq #(.W(8), .MERSENNE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  serial_add_seq #(.W(8), .MERSENNE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit m, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (m) begin bus1.in_valid = v; bus1.a = a; bus1.b = b; end
    else   begin bus0.in_valid = v; bus0.a = a; bus0.b = b; end
  endtask

  task automatic set_ord(input bit m, input logic r);
    if (m) bus1.out_ready = r;
    else   bus0.out_ready = r;
  endtask

  function automatic logic ir(input bit m);  return m ? bus1.in_ready  : bus0.in_ready;  endfunction
  function automatic logic ov(input bit m);  return m ? bus1.out_valid : bus0.out_valid; endfunction
  function automatic logic co(input bit m);  return m ? bus1.c_out     : bus0.c_out;     endfunction
  function automatic logic [7:0] sm(input bit m); return m ? bus1.sum  : bus0.sum;       endfunction

  // One transaction: accept, measure latency, optionally stall in DONE, then release.
  task automatic op(input bit m, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] exp_sum, input logic exp_c, input int exp_lat,
                    input int hold, input string tag);
    int lat;
    @(negedge clk);
    check({tag, ".idle_ready"}, 32'(ir(m)), 32'd1);
    set_in(m, 1'b1, a, b);
    @(posedge clk); #1;
    set_in(m, 1'b0, ~a, ~b);
    lat = 0;
    while (!ov(m) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".sum"}, 32'(sm(m)), 32'(exp_sum));
    check({tag, ".c_out"}, 32'(co(m)), 32'(exp_c));
    check({tag, ".busy"}, 32'(ir(m)), 32'd0);
    for (int i = 0; i < hold; i++) begin
      set_in(m, 1'b1, 8'h5a, 8'h33);
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(ov(m)), 32'd1);
      check({tag, ".hold_sum"}, 32'(sm(m)), 32'(exp_sum));
      check({tag, ".hold_ready"}, 32'(ir(m)), 32'd0);
    end
    set_in(m, 1'b0, 8'h00, 8'h00);
    set_ord(m, 1'b1);
    @(posedge clk); #1;
    set_ord(m, 1'b0);
    check({tag, ".release_valid"}, 32'(ov(m)), 32'd0);
    check({tag, ".release_ready"}, 32'(ir(m)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_in(1'b0, 1'b0, 8'h00, 8'h00);
    set_in(1'b1, 1'b0, 8'h00, 8'h00);
    set_ord(1'b0, 1'b0);
    set_ord(1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready",  32'(bus0.in_ready),  32'd1);
    check("reset.out_valid", 32'(bus0.out_valid), 32'd0);
    check("reset.sum",       32'(bus0.sum),       32'd0);
    check("reset.c_out",     32'(bus0.c_out),     32'd0);
    check("reset.m_ready",   32'(bus1.in_ready),  32'd1);
    rst_n = 1'b1;

    op(1'b0,  8'd55,  8'd17,  8'd72, 1'b0,  8, 0, "plain_55_17");
    op(1'b0, 8'd200, 8'd100,  8'd44, 1'b1,  8, 0, "plain_200_100");
    op(1'b0, 8'd255, 8'd255, 8'd254, 1'b1,  8, 0, "plain_255_255");
    op(1'b1, 8'd200, 8'd100,  8'd45, 1'b1, 16, 0, "mers_200_100");
    op(1'b1, 8'd255, 8'd255, 8'd255, 1'b1, 16, 0, "mers_255_255");
    op(1'b1,  8'd55,  8'd17,  8'd72, 1'b0,  8, 0, "mers_55_17");
    op(1'b0,  8'd10,  8'd20,  8'd30, 1'b0,  8, 5, "backpressure");

    // Abort mid-addition: 3+4 has partial sum bits in flight when reset hits.
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'd3, 8'd4);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 8'd0, 8'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort.in_ready",  32'(bus0.in_ready),  32'd1);
    check("abort.out_valid", 32'(bus0.out_valid), 32'd0);
    check("abort.sum",       32'(bus0.sum),       32'd0);
    check("abort.c_out",     32'(bus0.c_out),     32'd0);
    rst_n = 1'b1;
    op(1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 8, 0, "abort_fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
